// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the multi-port register file
// Provides default widths, the packed-port index helper and a popcount used by the scoreboard.
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int POP_W = 256;
  function automatic int pidx(input int port, input int width);
    return port * width;
  endfunction
  function automatic int unsigned popcount(input logic [POP_W-1:0] v);
    popcount = 0;
    for (int i = 0; i < POP_W; i++) popcount += 32'(v[i]);
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write busy bits and pending count
// Ports: clk, reset (sync, high); claim_en/claim_addr set a busy bit; clr is the one-hot mask of
// effective writes this cycle; rd_addr/rd_busy expose the registered bit per read port;
// busy_cnt is the registered population count of the busy bits.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  input  logic [2**ADDR_W-1:0]     clr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [ADDR_W:0]          busy_cnt
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DEPTH-1:0] busy_q, busy_d, set;
  logic [ADDR_W:0] busy_cnt_q;
  always_comb begin
    set = '0;
    set[claim_addr] = claim_en;
    // set is applied after clear so a new producer outranks the one completing; bit 0 never sets
    busy_d = ((busy_q & ~clr) | set) & ~DEPTH'(1);
  end
  always_ff @(posedge clk)
    if (reset) begin
      busy_q <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q <= busy_d;
      busy_cnt_q <= (ADDR_W+1)'(popcount(POP_W'(busy_d)));
    end
  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) rd_busy[i] = busy_q[rd_addr[pidx(i, ADDR_W) +: ADDR_W]];
  end
  assign busy_cnt = busy_cnt_q;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with bypass and pending-write scoreboard
// Ports: clk, reset (sync, high); rd_addr/rd_data/rd_busy packed per read port (combinational);
// wr_en/wr_addr/wr_data/wr_pc packed per write port (higher index wins); claim_en/claim_addr
// mark a destination pending; busy_cnt counts pending registers.
// Macro REGFILE_TRACE_EN: when defined, each effective write is printed with its wr_pc.
module regfile_mp import regfile_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_WR*32-1:0]     wr_pc,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic [ADDR_W:0]          busy_cnt
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [NUM_WR-1:0] win;
  logic [DEPTH-1:0] clr;
  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rv;
  // a port wins when enabled, not targeting $0 and not overridden by a higher-index port
  always_comb begin
    win = '0;
    clr = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      win[j] = wr_en[j] && wr_addr[pidx(j, ADDR_W) +: ADDR_W] != '0;
      for (int k = j + 1; k < NUM_WR; k++)
        if (wr_en[k] && wr_addr[pidx(k, ADDR_W) +: ADDR_W] == wr_addr[pidx(j, ADDR_W) +: ADDR_W]) win[j] = 1'b0;
      if (win[j]) clr[wr_addr[pidx(j, ADDR_W) +: ADDR_W]] = 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (reset) regs_q <= '{default: '0};
    else
      for (int j = 0; j < NUM_WR; j++)
        if (win[j]) regs_q[wr_addr[pidx(j, ADDR_W) +: ADDR_W]] <= wr_data[pidx(j, DATA_W) +: DATA_W];
  always_comb begin
    rd_data = '0;
    ra = '0;
    rv = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = rd_addr[pidx(i, ADDR_W) +: ADDR_W];
      rv = regs_q[ra];
      for (int j = 0; j < NUM_WR; j++)
        if (BYPASS != 0 && win[j] && wr_addr[pidx(j, ADDR_W) +: ADDR_W] == ra) rv = wr_data[pidx(j, DATA_W) +: DATA_W];
      rd_data[pidx(i, DATA_W) +: DATA_W] = ra == '0 ? '0 : rv;
    end
  end
  regfile_scoreboard #(.ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) u_sb (
    .clk(clk),
    .reset(reset),
    .claim_en(claim_en),
    .claim_addr(claim_addr),
    .clr(clr),
    .rd_addr(rd_addr),
    .rd_busy(rd_busy),
    .busy_cnt(busy_cnt)
  );
`ifdef REGFILE_TRACE_EN
  always_ff @(posedge clk)
    if (!reset)
      for (int j = 0; j < NUM_WR; j++)
        if (win[j]) $display("@%h: $%d <= %h", wr_pc[pidx(j, 32) +: 32], wr_addr[pidx(j, ADDR_W) +: ADDR_W], wr_data[pidx(j, DATA_W) +: DATA_W]);
`else
  logic unused_pc;
  assign unused_pc = ^wr_pc;
`endif
endmodule
